// File: rtl/quadrature_decoder_if.sv
// Bundles the raw phase inputs and decoded outputs of the quadrature front end.
interface quadrature_decoder_if;
   logic       a_in;
   logic       b_in;
   logic       step;
   logic       up_down;
   logic       err;
   logic [7:0] err_count;

   modport master (
      output a_in,
      output b_in,
      input  step,
      input  up_down,
      input  err,
      input  err_count
   );

   modport slave (
      input  a_in,
      input  b_in,
      output step,
      output up_down,
      output err,
      output err_count
   );
endinterface

// File: rtl/quadrature_decoder.sv
// Quadrature front end: synchronizes and glitch-filters raw A/B phases, then
// decodes the Gray sequence into step pulses, a held direction level, and an
// error pulse with saturating count for illegal double-edge transitions.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_INIT | settle after reset; prev tracks filtered {A,B}, no outputs
//   ST_RUN  | decode filtered {A,B} against prev every cycle
module quadrature_decoder #(
   parameter int unsigned FILTER_CYCLES = 3
) (
   input logic                clk,
   input logic                reset,
   quadrature_decoder_if.slave bus
);

   localparam logic [0:0] ST_INIT = 1'b0;
   localparam logic [0:0] ST_RUN  = 1'b1;

   // Filter flips on the cycle that would make the disagreement run reach FILTER_CYCLES.
   localparam logic [3:0] FILT_LAST = 4'(FILTER_CYCLES - 1);
   // INIT spans FILTER_CYCLES+3 edges: load FILTER_CYCLES+2 and leave at zero.
   localparam logic [4:0] INIT_LOAD = 5'(FILTER_CYCLES + 2);

   logic [1:0] sync_a;
   logic [1:0] sync_b;
   logic       filt_a;
   logic       filt_b;
   logic [3:0] cnt_a;
   logic [3:0] cnt_b;

   logic [0:0] state;
   logic [4:0] init_cnt;
   logic [1:0] prev;
   logic [1:0] cur;

   logic       step_r;
   logic       up_down_r;
   logic       err_r;
   logic [7:0] err_count_r;

   logic       is_step;
   logic       is_err;
   logic       step_up;

   // Two-flop synchronizers for the asynchronous phase inputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync_a <= 2'b00;
         sync_b <= 2'b00;
      end else begin
         sync_a <= {sync_a[0], bus.a_in};
         sync_b <= {sync_b[0], bus.b_in};
      end
   end

   // Phase A filter: flip only after a sustained disagreement.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         filt_a <= 1'b0;
         cnt_a  <= 4'd0;
      end else if (sync_a[1] == filt_a) begin
         cnt_a <= 4'd0;
      end else if (cnt_a == FILT_LAST) begin
         filt_a <= ~filt_a;
         cnt_a  <= 4'd0;
      end else begin
         cnt_a <= cnt_a + 4'd1;
      end
   end

   // Phase B filter: same rule as phase A.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         filt_b <= 1'b0;
         cnt_b  <= 4'd0;
      end else if (sync_b[1] == filt_b) begin
         cnt_b <= 4'd0;
      end else if (cnt_b == FILT_LAST) begin
         filt_b <= ~filt_b;
         cnt_b  <= 4'd0;
      end else begin
         cnt_b <= cnt_b + 4'd1;
      end
   end

   // Classify the filtered transition; up order is 00->10->11->01->00.
   always_comb begin
      cur     = {filt_a, filt_b};
      is_err  = ((cur ^ prev) == 2'b11);
      is_step = ((cur ^ prev) == 2'b01) || ((cur ^ prev) == 2'b10);
      step_up = 1'b0;
      case ({prev, cur})
         4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: step_up = 1'b1;
         default:                                 step_up = 1'b0;
      endcase
   end

   // Sequencer and registered outputs; prev always follows the filtered state.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= ST_INIT;
         init_cnt    <= INIT_LOAD;
         prev        <= 2'b00;
         step_r      <= 1'b0;
         up_down_r   <= 1'b1;
         err_r       <= 1'b0;
         err_count_r <= 8'd0;
      end else begin
         step_r <= 1'b0;
         err_r  <= 1'b0;
         prev   <= cur;
         case (state)
            ST_INIT: begin
               if (init_cnt == 5'd0) begin
                  state <= ST_RUN;
               end else begin
                  init_cnt <= init_cnt - 5'd1;
               end
            end
            default: begin
               if (is_err) begin
                  err_r <= 1'b1;
                  if (err_count_r != 8'hFF) begin
                     err_count_r <= err_count_r + 8'd1;
                  end
               end else if (is_step) begin
                  step_r    <= 1'b1;
                  up_down_r <= step_up;
               end
            end
         endcase
      end
   end

   assign bus.step      = step_r;
   assign bus.up_down   = up_down_r;
   assign bus.err       = err_r;
   assign bus.err_count = err_count_r;

endmodule

// File: tb/tb_quadrature_decoder.sv
// Bench for quadrature_decoder: directed scenarios plus random phase activity,
// every cycle compared against a behavioural model of the decoder.
module tb_quadrature_decoder;
   localparam int FC = 3;

   logic clk   = 1'b0;
   logic reset = 1'b0;

   quadrature_decoder_if bus();

   quadrature_decoder #(.FILTER_CYCLES(FC)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int n_step = 0;
   int n_err  = 0;

   // behavioural model state
   logic [1:0]  m_sy1, m_sy2, m_filt, m_prev;
   logic [31:0] m_hist_a, m_hist_b;
   logic        m_step, m_ud, m_err;
   int          m_cnt;
   int          m_edge;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int pos(input logic [1:0] ab);
      case (ab)
         2'b00:   return 0;
         2'b10:   return 1;
         2'b11:   return 2;
         default: return 3;
      endcase
   endfunction

   task automatic model_reset();
      m_sy1 = 2'b00; m_sy2 = 2'b00; m_filt = 2'b00; m_prev = 2'b00;
      m_hist_a = '0; m_hist_b = '0;
      m_step = 1'b0; m_ud = 1'b1; m_err = 1'b0;
      m_cnt = 0; m_edge = 0;
   endtask

   // One rising edge of the reference: a phase flips once its synchronized
   // value has disagreed for the last FC edges; the decode uses the position
   // distance along the up sequence (1 = up, 3 = down, 2 = illegal).
   task automatic model_edge(input logic a, input logic b);
      logic [1:0]  f_old;
      logic [1:0]  f_new;
      logic [31:0] mask;
      int          d;
      f_old = m_filt;
      f_new = f_old;
      mask  = (32'd1 << FC) - 32'd1;
      m_hist_a = {m_hist_a[30:0], m_sy2[1]};
      m_hist_b = {m_hist_b[30:0], m_sy2[0]};
      if (((m_hist_a ^ {32{f_old[1]}}) & mask) == mask) f_new[1] = ~f_old[1];
      if (((m_hist_b ^ {32{f_old[0]}}) & mask) == mask) f_new[0] = ~f_old[0];
      m_step = 1'b0;
      m_err  = 1'b0;
      if (m_edge > FC + 2) begin
         d = (pos(f_old) - pos(m_prev) + 4) % 4;
         if (d == 1) begin m_step = 1'b1; m_ud = 1'b1; end
         else if (d == 3) begin m_step = 1'b1; m_ud = 1'b0; end
         else if (d == 2) begin
            m_err = 1'b1;
            if (m_cnt < 255) m_cnt++;
         end
      end
      m_prev = f_old;
      m_filt = f_new;
      m_sy2  = m_sy1;
      m_sy1  = {a, b};
      m_edge++;
   endtask

   task automatic check_all(input string ctx);
      chk({ctx, "_step"},      {7'd0, bus.step},    {7'd0, m_step});
      chk({ctx, "_up_down"},   {7'd0, bus.up_down}, {7'd0, m_ud});
      chk({ctx, "_err"},       {7'd0, bus.err},     {7'd0, m_err});
      chk({ctx, "_err_count"}, bus.err_count,       m_cnt[7:0]);
   endtask

   task automatic tick();
      @(posedge clk);
      if (reset) model_edge(bus.a_in, bus.b_in);
      @(negedge clk);
      check_all("cyc");
      if (bus.step === 1'b1) n_step++;
      if (bus.err === 1'b1) n_err++;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic hold(input logic a, input logic b, input int cyc, output int lat);
      lat = 0;
      bus.a_in = a;
      bus.b_in = b;
      for (int i = 1; i <= cyc; i++) begin
         tick();
         if (bus.step === 1'b1 && lat == 0) lat = i;
      end
   endtask

   initial begin
      int lat;
      int s0, e0;
      logic ud0;
      bit seen;
      logic [1:0] r;

      bus.a_in = 1'b0;
      bus.b_in = 1'b0;
      model_reset();

      // reset values
      @(negedge clk);
      check_all("reset");
      reset = 1'b1;
      run(FC + 3 + 2);

      // forward stepping
      s0 = n_step; e0 = n_err;
      hold(1'b1, 1'b0, 10, lat); chk("fwd_lat_10", lat[7:0], 8'd6);
      hold(1'b1, 1'b1, 10, lat); chk("fwd_lat_11", lat[7:0], 8'd6);
      hold(1'b0, 1'b1, 10, lat); chk("fwd_lat_01", lat[7:0], 8'd6);
      hold(1'b0, 1'b0, 10, lat); chk("fwd_lat_00", lat[7:0], 8'd6);
      chk("fwd_steps", 8'(n_step - s0), 8'd4);
      chk("fwd_errs", 8'(n_err - e0), 8'd0);
      chk("fwd_dir", {7'd0, bus.up_down}, 8'd1);

      // direction reversal
      hold(1'b1, 1'b0, 10, lat); chk("rev_up_dir", {7'd0, bus.up_down}, 8'd1);
      hold(1'b0, 1'b0, 10, lat); chk("rev_lat", lat[7:0], 8'd6);
      chk("rev_down_dir", {7'd0, bus.up_down}, 8'd0);

      // glitch rejection
      s0 = n_step; e0 = n_err;
      hold(1'b1, 1'b0, 2, lat);
      hold(1'b0, 1'b0, 12, lat);
      chk("glitch2_steps", 8'(n_step - s0), 8'd0);
      chk("glitch2_errs", 8'(n_err - e0), 8'd0);
      hold(1'b1, 1'b0, 3, lat);
      hold(1'b0, 1'b0, 12, lat);
      chk("glitch3_steps", 8'(n_step - s0), 8'd2);
      chk("glitch3_dir", {7'd0, bus.up_down}, 8'd0);

      // illegal double edge and saturation
      s0 = n_step; e0 = n_err; ud0 = bus.up_down;
      hold(1'b1, 1'b1, 10, lat);
      chk("dbl_errs", 8'(n_err - e0), 8'd1);
      chk("dbl_count", bus.err_count, 8'd1);
      chk("dbl_steps", 8'(n_step - s0), 8'd0);
      chk("dbl_dir", {7'd0, bus.up_down}, {7'd0, ud0});
      for (int i = 0; i < 300; i++) begin
         if (i % 2 == 0) hold(1'b0, 1'b0, 5, lat);
         else            hold(1'b1, 1'b1, 5, lat);
      end
      run(8);
      chk("sat_count", bus.err_count, 8'd255);

      // random activity against the model
      for (int i = 0; i < 250; i++) begin
         r = 2'($urandom_range(0, 3));
         hold(r[1], r[0], int'($urandom_range(1, 7)), lat);
      end
      hold(bus.a_in, bus.b_in, 10, lat);

      // non-zero start
      bus.a_in = 1'b1; bus.b_in = 1'b1;
      reset = 1'b0;
      model_reset();
      run(2);
      reset = 1'b1;
      s0 = n_step; e0 = n_err;
      run(FC + 3 + 5);
      chk("nz_init_steps", 8'(n_step - s0), 8'd0);
      chk("nz_init_errs", 8'(n_err - e0), 8'd0);
      hold(1'b0, 1'b1, 10, lat);
      chk("nz_lat", lat[7:0], 8'd6);
      chk("nz_dir", {7'd0, bus.up_down}, 8'd1);

      // mid-operation reset while step is high
      hold(1'b1, 1'b0, 10, lat);
      chk("mid_pre_count", bus.err_count, 8'd1);
      bus.a_in = 1'b0; bus.b_in = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 12 && !seen; i++) begin
         tick();
         if (bus.step === 1'b1) seen = 1'b1;
      end
      chk("mid_step_seen", {7'd0, seen}, 8'd1);
      chk("mid_pre_dir", {7'd0, bus.up_down}, 8'd0);
      #2;
      reset = 1'b0;
      #1;
      chk("mid_rst_step", {7'd0, bus.step}, 8'd0);
      chk("mid_rst_dir", {7'd0, bus.up_down}, 8'd1);
      chk("mid_rst_count", bus.err_count, 8'd0);
      model_reset();
      @(negedge clk);
      reset = 1'b1;
      s0 = n_step;
      run(FC + 3 + 3);
      chk("mid_post_steps", 8'(n_step - s0), 8'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/quadrature_decoder.md
# quadrature_decoder

Front-end stage for the 4-bit up/down counter. It takes raw two-phase quadrature inputs, synchronizes and glitch-filters them, and decodes the Gray-code sequence. Each valid transition produces a one-cycle `step` pulse and a registered `up_down` direction level that drive the counter directly. Illegal double-edge transitions are flagged and counted.

## Interface
- `FILTER_CYCLES`, default 3: consecutive cycles a synchronized input must differ from its filtered value before the filtered value flips. Legal range is 1..15.
- `clk`  input  1  system clock; all logic on rising edge.
- `reset`  input  1  asynchronous, active-low reset.
- `a_in`  input  1  raw phase A, asynchronous to `clk`.
- `b_in`  input  1  raw phase B, asynchronous to `clk`.
- `step`  output  1  one-cycle pulse per valid quadrature transition.
- `up_down`  output  1  direction of the last valid step (1 = up, 0 = down); held between steps.
- `err`  output  1  one-cycle pulse when both filtered phases change in the same cycle.
- `err_count`  output  8  saturating count of `err` pulses.

## Operation
- Reset values: sync flops 0, filtered A/B 0, filter counters 0, previous state 00, `step` 0, `up_down` 1, `err` 0, `err_count` 0, FSM in INIT.
- Synchronizer: two flops per phase.
- Filter, per phase, 4-bit counter:
  - When the synchronized value equals the filtered value, the counter clears.
  - Otherwise the counter increments.
  - When the counter reaches `FILTER_CYCLES`, the filtered value flips and the counter clears.
  - A disagreement shorter than `FILTER_CYCLES` cycles is discarded.
- FSM states:
  - INIT: entered on reset. Lasts exactly `FILTER_CYCLES`+3 cycles after reset deasserts, counted by a 5-bit counter. Each cycle, prev is loaded with filtered {A,B}. `step` and `err` are forced to 0. On the last INIT cycle the FSM moves to RUN.
  - RUN: each cycle, compare filtered {A,B} (cur) against prev, then load prev with cur.
- Decode in RUN, state written {A,B}:
  - Up sequence: 00→10→11→01→00.
  - Down sequence: the reverse order.
  - cur equal to prev: no output.
  - Single-bit change along the up sequence: `step`=1 and `up_down`=1 on the next edge.
  - Single-bit change along the down sequence: `step`=1 and `up_down`=0 on the next edge.
  - Both bits changed (00↔11 or 10↔01): `err`=1 and no step. `up_down` is unchanged, and prev still takes cur.
- `err_count` increments on each `err` pulse and saturates at 255 with no wrap.
- `step`, `up_down` and `err` are registered outputs with no combinational path from any input.
- Reset asserted mid-operation forces all state to its reset values immediately, without waiting for `clk`. Operation resumes through INIT.

## Timing
- Step latency: a stable phase change first sampled at rising edge 0 gives `step` high after edge `FILTER_CYCLES`+2. That is `FILTER_CYCLES`+3 edges inclusive, so 6 edges at the default.
- `up_down` updates on the same edge that `step` rises.
- `step` and `err` are high for exactly one cycle.
- `step` and `err` are never high in the same cycle.
- Maximum step rate: one step per `FILTER_CYCLES` cycles per phase. Inputs toggling faster than this are suppressed by the filter.
- `err_count` updates on the same edge that `err` rises.
- Phase inputs that are stable through reset produce no `step` or `err` when INIT ends.

## Test plan
- **Forward stepping.** `FILTER_CYCLES`=3, inputs 00 through reset. After INIT, drive 10, 11, 01, 00, each held 10 cycles. Required: 4 `step` pulses, each 6 edges after the input change, `up_down`=1 throughout, `err` never asserted.
- **Direction reversal.** From 00, drive 10 then 00. Required: first `step` with `up_down`=1; second `step` with `up_down` falling to 0 on the same edge as `step`.
- **Glitch rejection.** From 00, pulse `a_in` high for 2 cycles. Required: no `step`, no `err`. Repeat with a 3-cycle pulse. Required: one up step (00→10), then one down step (10→00).
- **Illegal double edge.** From 00, change both inputs to 11 on the same cycle. Required: one `err` pulse, `err_count`=1, no `step`, `up_down` unchanged. Then apply 300 illegal double edges. Required: `err_count` stops at 255.
- **Non-zero start.** Hold inputs at 11 through reset release. Required: no `step` and no `err` during or after INIT. Then drive 01. Required: `step` with `up_down`=1.
- **Mid-operation reset.** Assert `reset` low between edges while `step` is high. Required: immediately `step`=0, `up_down`=1, `err_count`=0. After release, `step` stays 0 for at least `FILTER_CYCLES`+3 cycles.
